keypad_event_fifo: RTL and testbench
====================================

Name: keypad_event_fifo

Overview:
- Downstream consumer of the hex keypad scanner. Takes the scanner's key code, its valid strobe and the synchronized "any row active" level.
- Debounces press and release, emits exactly one event per key press and queues events in a small FIFO.
- FIFO output is a ready/valid stream for the host/CPU-side logic.
- Flags overflow when events are lost.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DEBOUNCE_CYCLES, 4, consecutive cycles of stable key_held required to confirm a press or a release; at least 1.
- REPEAT_DELAY, 64, cycles from press confirmation to the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeats (optional feature only).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- key_code  in  4  scanner key code; sampled only when key_valid=1.
- key_valid  in  1  scanner valid; may pulse for a single cycle per scan.
- key_held  in  1  synchronized level, 1 while any row is asserted.
- evt_code  out  4  code at the FIFO head.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head when evt_valid and evt_ready are both 1.
- fifo_count  out  log2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky; set when a push is dropped.
- overflow_clr  in  1  clears overflow.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM goes to IDLE; debounce counter, FIFO pointers and count go to 0. evt_valid=0, evt_code=0, fifo_count=0, overflow=0, busy=0.
- Reset mid-operation: any entries and any pending press are discarded.
- IDLE:
  - On key_valid=1, latch key_code into cap_code, clear the counter, go to CONFIRM.
  - key_held alone does not leave IDLE.
- CONFIRM:
  - Each cycle with key_held=1 increments the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with key_held=1, push cap_code on that cycle and go to HELD.
  - key_held=0 in any cycle returns to IDLE with no push (bounce rejected).
  - key_valid is ignored in this state; the code is not re-latched.
- HELD:
  - Counter is cleared on entry.
  - key_held=0 clears the counter and goes to RELEASE.
  - key_valid with a different code is ignored (no roll-over).
- RELEASE:
  - Each cycle with key_held=0 increments the counter.
  - At DEBOUNCE_CYCLES-1, go to IDLE.
  - key_held=1 before then returns to HELD with no new push.
- Press latency: push occurs DEBOUNCE_CYCLES cycles after the cycle in which CONFIRM is entered. The entry becomes visible on evt_valid in the following cycle.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - evt_code is driven combinationally from the head entry; it is 0 when empty.
  - Push when full and no pop in the same cycle: data is dropped and overflow is set.
  - Push and pop in the same cycle when full: both succeed; count is unchanged.
  - Push and pop in the same cycle otherwise: both succeed; count is unchanged.
  - Pop when empty: no effect.
- overflow: overflow_clr clears it. If overflow_clr and a dropping push occur in the same cycle, set wins.
- busy = (state != IDLE).

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined:
  - In HELD, a repeat counter counts cycles from entry.
  - At REPEAT_DELAY it pushes cap_code again.
  - After that it pushes every REPEAT_PERIOD cycles while in HELD.
  - The repeat counter resets on entry to HELD from CONFIRM. It is frozen, not reset, during RELEASE.
  - Repeat pushes obey the same full/overflow rules as press pushes.
- When undefined: no repeat counter is built; exactly one push per confirmed press.

Test Plan:
- Clean press: reset; key_valid pulse with code 0xA, then key_held=1 for 20 cycles, then key_held=0 -> exactly one entry 0xA; evt_valid rises DEBOUNCE_CYCLES+1 cycles after the pulse; fifo_count=1.
- Bounce rejection: key_valid with 0x5, key_held=1 for 2 cycles then 0 -> no push, FSM back in IDLE, busy=0.
- Release glitch: confirmed press of 0x3; key_held drops for 2 cycles, then high again for 10, then low for 10 -> exactly one entry 0x3.
- Overflow: 9 presses with codes 0..8 and evt_ready=0 (DEPTH=8) -> fifo_count=8, overflow=1. Draining yields 0..7 in order. overflow_clr then clears the flag.
- Simultaneous push and pop with a full FIFO and evt_ready=1 -> no overflow, count stays 8, head advances; pointer wrap verified over 20 events.
- With KEYPAD_AUTOREPEAT_EN and defaults: 0xF held 120 cycles after confirmation -> pushes at offsets 0, 64, 80, 96 and 112, five entries total. Without the macro -> one entry.

Source files
------------

// File: rtl/keypad_event_fifo.sv
// Keypad event FIFO: debounces scanner presses/releases, queues one code per press.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_event_fifo #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               key_code,
  input  logic                     key_valid,
  input  logic                     key_held,
  output logic [3:0]               evt_code,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_event_fifo: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cap_q, cap_d;
  logic            press_push;
  logic            push_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    press_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          cap_d   = key_code;
          cnt_d   = '0;
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        // any low cycle while confirming is treated as bounce
        if (!key_held) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          press_push = 1'b1;
          cnt_d      = '0;
          state_d    = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!key_held) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (key_held) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  // rep_q = cycles since the press push; holds its value through RELEASE
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  always_comb begin
    rep_d    = rep_q;
    rep_push = 1'b0;
    if (state_q == CONFIRM && state_d == HELD) begin
      rep_d = RW'(1);
    end else if (state_q == HELD && key_held) begin
      if (rep_q == RW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
        rep_push = 1'b1;
        rep_d    = RW'(REPEAT_DELAY + 1);
      end else begin
        rep_push = (rep_q == RW'(REPEAT_DELAY));
        rep_d    = rep_q + RW'(1);
      end
    end
  end

  assign push_req = press_push | rep_push;
`else
  assign push_req = press_push;
`endif

  // event storage
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          full, empty, pop, push_ok, drop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = evt_ready && !empty;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= cap_q;
  end

  assign evt_code   = empty ? 4'h0 : mem_q[rd_q];
  assign evt_valid  = !empty;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Directed + randomized bench for keypad_event_fifo with a queue-based reference model.
module tb_keypad_event_fifo;
  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int RD    = 64;
  localparam int RP    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid, key_held;
  logic [3:0] evt_code;
  logic       evt_valid, evt_ready;
  logic [3:0] fifo_count;
  logic       overflow, overflow_clr, busy;

  keypad_event_fifo #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .evt_code(evt_code), .evt_valid(evt_valid), .evt_ready(evt_ready), .fifo_count(fifo_count),
    .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] mq[$];
  logic       movf;
  int         rdy_mode;   // 0 never, 1 always, 2 random, 3 only on expected push cycles
  logic       clr_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] head;
    head = (mq.size() != 0) ? mq[0] : 4'h0;
    chk({tag, "/valid"}, 32'(evt_valid), 32'(mq.size() != 0));
    chk({tag, "/code"},  32'(evt_code),  32'(head));
    chk({tag, "/count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, "/ovf"},   32'(overflow),  32'(movf));
  endtask

  // One clock: drive inputs, advance the model by this cycle's pop/push, compare.
  task automatic step(input logic v, input logic [3:0] c, input logic h, input logic ep,
                      input logic [3:0] pd, input string tag);
    logic dropped;
    key_valid = v; key_code = c; key_held = h;
    case (rdy_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      2:       evt_ready = ($urandom_range(0, 3) == 0);
      default: evt_ready = ep;
    endcase
    if (rdy_mode == 2) clr_req = ($urandom_range(0, 15) == 0);
    overflow_clr = clr_req;
    @(posedge clk);
    if (evt_ready && mq.size() != 0) void'(mq.pop_front());
    dropped = 1'b0;
    if (ep) begin
      if (mq.size() < DEPTH) mq.push_back(pd);
      else begin dropped = 1'b1; movf = 1'b1; end
    end
    if (clr_req && !dropped) movf = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  // A press is accepted iff held for DB cycles after the pulse; repeats are
  // spaced from that confirmation point.
  function automatic bit exp_push(input int i, input int hold);
    if (hold < DB) return 1'b0;
    if (i == DB) return 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    if (i > DB && i <= hold && (i - DB) >= RD && ((i - DB - RD) % RP) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Pulse code, hold for `hold` cycles (with stray scanner pulses), release cleanly.
  task automatic press(input logic [3:0] code, input int hold, input string tag);
    logic       v;
    logic [3:0] c;
    for (int i = 0; i <= hold + DB + 1; i++) begin
      v = (i == 0) || (i <= hold && i % 3 == 0);
      c = (i == 0) ? code : 4'($urandom_range(0, 15));
      step(v, c, (i <= hold), exp_push(i, hold), code, tag);
      if (i == 0) chk({tag, "/busy_on"}, 32'(busy), 32'd1);
    end
    chk({tag, "/busy_off"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    key_valid = 1'b0; key_held = 1'b0; evt_ready = 1'b0; overflow_clr = 1'b0; clr_req = 1'b0;
    reset = 1'b1;
    #2;
    mq.delete();
    movf = 1'b0;
    check_outputs(tag);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_held = 1'b0; key_code = 4'h0;
    evt_ready = 1'b0; overflow_clr = 1'b0; clr_req = 1'b0; rdy_mode = 0;
    movf = 1'b0;
    #1;
    do_reset("reset");

    // clean press: single entry 0xA, visible DB+1 cycles after the pulse
    press(4'hA, 20, "clean");
    chk("clean/count1", 32'(fifo_count), 32'd1);
    chk("clean/code", 32'(evt_code), 32'hA);

    // bounce rejection
    press(4'h5, 2, "bounce");
    chk("bounce/count", 32'(fifo_count), 32'd1);

    // release glitch: low for 2, high again, then clean release
    do_reset("reset2");
    step(1, 4'h3, 1, 0, 4'h3, "glitch");
    for (int i = 1; i <= 6; i++)  step(0, 4'h9, 1, (i == DB), 4'h3, "glitch");
    for (int i = 0; i < 2; i++)   step(0, 4'h0, 0, 0, 4'h3, "glitch");
    for (int i = 0; i < 10; i++)  step(0, 4'h0, 1, 0, 4'h3, "glitch");
    for (int i = 0; i < 10; i++)  step(0, 4'h0, 0, 0, 4'h3, "glitch");
    chk("glitch/count", 32'(fifo_count), 32'd1);
    chk("glitch/code", 32'(evt_code), 32'h3);
    chk("glitch/busy", 32'(busy), 32'd0);

    // overflow: 9 presses into an 8-deep queue, then drain in order and clear
    do_reset("reset3");
    rdy_mode = 0;
    for (int k = 0; k < 9; k++) press(4'(k), 6, "ovf_fill");
    chk("ovf/count", 32'(fifo_count), 32'd8);
    chk("ovf/flag", 32'(overflow), 32'd1);
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) begin
      chk("drain/head", 32'(evt_code), 32'(k));
      step(0, 4'h0, 0, 0, 4'h0, "drain");
    end
    rdy_mode = 0;
    clr_req = 1'b1;
    step(0, 4'h0, 0, 0, 4'h0, "ovf_clr");
    clr_req = 1'b0;
    chk("ovf/cleared", 32'(overflow), 32'd0);

    // full queue with push and pop in the same cycle; pointers wrap repeatedly
    do_reset("reset4");
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) press(4'(k), 6, "full_fill");
    rdy_mode = 3;
    for (int k = 0; k < 20; k++) press(4'(k + 8), 6, "full_pp");
    chk("full_pp/count", 32'(fifo_count), 32'd8);
    chk("full_pp/ovf", 32'(overflow), 32'd0);
    chk("full_pp/head", 32'(evt_code), 32'(4'(20)));

    // long hold: auto-repeat only when the feature is built
    do_reset("reset5");
    rdy_mode = 0;
    press(4'hF, DB + 120, "repeat");
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("repeat/count", 32'(fifo_count), 32'd5);
`else
    chk("repeat/count", 32'(fifo_count), 32'd1);
`endif

    // reset mid-press with entries queued discards everything
    step(1, 4'h7, 1, 0, 4'h7, "midrst");
    step(0, 4'h7, 1, 0, 4'h7, "midrst");
    #3 reset = 1'b1;
    #1;
    mq.delete();
    movf = 1'b0;
    check_outputs("midrst/async");
    chk("midrst/busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) step(0, 4'h7, 1, 0, 4'h7, "midrst_held");
    chk("midrst/idle", 32'(busy), 32'd0);
    step(0, 4'h0, 0, 0, 4'h0, "midrst_rel");

    // randomized presses, pops and overflow clears against the model
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      press(4'($urandom_range(0, 15)), $urandom_range(0, 9), "rand");
      for (int g = $urandom_range(0, 2); g > 0; g--)
        step(0, 4'($urandom_range(0, 15)), 0, 0, 4'h0, "rand_gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
